reset_button_ctrl: RTL and testbench

- Front end of the game reset chain.
- Synchronises and debounces the three raw active-low DE0 pushbuttons.
- Detects a deliberate "all three held" gesture and issues a fixed-length 3'b111 reset request on reset_req.
- reset_req drives reset_in[2:0] of the staged reset-delay block.
- Also exports clean per-key levels and press pulses to game logic.

---
 rtl/reset_button_ctrl.sv | 113 +++++++++++
 tb/tb_reset_button_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_button_ctrl.sv
// Pushbutton front end: 2-flop synchronise and debounce of three active-low keys,
// plus an "all three held" gesture that issues one fixed-length 3'b111 reset request.
module reset_button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 100000000,
    parameter int unsigned PULSE_CYCLES    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] key_n,
    output logic [2:0] key_pressed,
    output logic [2:0] key_edge,
    output logic       hold_active,
    output logic [2:0] reset_req
);
    localparam logic [19:0] DB_LAST    = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [26:0] HOLD_LAST  = 27'(HOLD_CYCLES - 1);
    localparam logic [7:0]  PULSE_LAST = 8'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, FIRE, WAIT_RELEASE} state_t;

    state_t      state;
    logic [2:0]  sync1, sync2, level, settle, rise;
    logic [19:0] db_cnt [3];
    logic [26:0] hold_cnt;
    logic [7:0]  pulse_cnt;

    assign level = ~sync2;

    always_comb begin
        settle = '0;
        for (int unsigned i = 0; i < 3; i++)
            settle[i] = (level[i] != key_pressed[i]) && (db_cnt[i] == DB_LAST);
        rise = settle & level;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1       <= '1;
            sync2       <= '1;
            key_pressed <= '0;
            key_edge    <= '0;
            for (int unsigned i = 0; i < 3; i++)
                db_cnt[i] <= '0;
        end else begin
            sync1    <= key_n;
            sync2    <= sync1;
            key_edge <= (state == FIRE || state == WAIT_RELEASE) ? '0 : rise;
            for (int unsigned i = 0; i < 3; i++) begin
                if (level[i] == key_pressed[i]) begin
                    db_cnt[i] <= '0;
                end else if (settle[i]) begin
                    key_pressed[i] <= level[i];
                    db_cnt[i]      <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 20'd1;
                end
            end
        end
    end

    // The entry edge counts as the first held cycle, so FIRE lands HOLD_CYCLES
    // edges after key_pressed became 3'b111.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            pulse_cnt   <= '0;
            hold_active <= 1'b0;
            reset_req   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_pressed == 3'b111) begin
                        state       <= HOLD;
                        hold_active <= 1'b1;
                        hold_cnt    <= 27'd1;
                    end else begin
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (key_pressed != 3'b111) begin
                        state       <= IDLE;
                        hold_active <= 1'b0;
                        hold_cnt    <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state       <= FIRE;
                        hold_active <= 1'b0;
                        hold_cnt    <= '0;
                        pulse_cnt   <= '0;
                        reset_req   <= '1;
                    end else begin
                        hold_cnt <= hold_cnt + 27'd1;
                    end
                end
                FIRE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state     <= WAIT_RELEASE;
                        reset_req <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt + 8'd1;
                    end
                end
                WAIT_RELEASE: begin
                    if (key_pressed == 3'b000)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reset_button_ctrl.sv
// Bench for reset_button_ctrl: table vectors, directed gesture sequences and random key
// activity, all checked against a window/timestamp reference model.
module tb_reset_button_ctrl;
    localparam int D = 4;
    localparam int H = 10;
    localparam int P = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] key_n = 3'b111;
    logic [2:0] key_pressed, key_edge, reset_req;
    logic       hold_active;

    reset_button_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES(H),
        .PULSE_CYCLES(P)
    ) dut (
        .clock(clock),
        .reset(reset),
        .key_n(key_n),
        .key_pressed(key_pressed),
        .key_edge(key_edge),
        .hold_active(hold_active),
        .reset_req(reset_req)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: a key level flips once the last D synchronised samples all
    // disagree with it; the gesture is tracked with edge timestamps.
    logic [2:0] m_hist [0:D];
    logic [2:0] m_kp, m_edge, m_req;
    logic       m_hold;
    int         m_phase, m_hold_since, m_fire_start;
    int         ecount = 0;

    task automatic model_edge(input logic rst, input logic [2:0] kn);
        logic [2:0] kp_prev, flip;
        int ph_prev;
        ecount++;
        if (rst) begin
            for (int j = 0; j <= D; j++) m_hist[j] = 3'b000;
            m_kp = 3'b000; m_edge = 3'b000; m_req = 3'b000; m_hold = 1'b0;
            m_phase = 0;
        end else begin
            kp_prev = m_kp;
            ph_prev = m_phase;
            flip = 3'b111;
            for (int j = 1; j <= D; j++) flip = flip & (m_hist[j] ^ kp_prev);
            m_kp   = kp_prev ^ flip;
            m_edge = (ph_prev >= 2) ? 3'b000 : (flip & m_kp);
            case (ph_prev)
                0: if (kp_prev == 3'b111) begin m_phase = 1; m_hold_since = ecount; end
                1: begin
                    if (kp_prev != 3'b111) m_phase = 0;
                    else if (ecount - m_hold_since == H - 1) begin
                        m_phase = 2; m_fire_start = ecount;
                    end
                end
                2: if (ecount - m_fire_start == P) m_phase = 3;
                3: if (kp_prev == 3'b000) m_phase = 0;
                default: m_phase = 0;
            endcase
            m_hold = (m_phase == 1);
            m_req  = (m_phase == 2) ? 3'b111 : 3'b000;
            for (int j = D; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = ~kn;
        end
    endtask

    task automatic step(input logic rst, input logic [2:0] kn);
        reset = rst;
        key_n = kn;
        @(posedge clock);
        model_edge(rst, kn);
        #1;
        checks++;
        if ({key_pressed, key_edge, hold_active, reset_req} !== {m_kp, m_edge, m_hold, m_req}) begin
            errors++;
            $display("FAIL model edge%0d got kp=%b ke=%b hold=%b req=%b expected kp=%b ke=%b hold=%b req=%b",
                     ecount, key_pressed, key_edge, hold_active, reset_req, m_kp, m_edge, m_hold, m_req);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run_until_kp(input logic [2:0] kn, input logic [2:0] want, output int at);
        at = -1;
        for (int n = 0; n < 60; n++) begin
            step(1'b0, kn);
            if (key_pressed == want) begin at = ecount; break; end
        end
        if (at < 0) chk("wait_key_pressed_timeout", 0, 1);
    endtask

    task automatic run_until_req(input logic [2:0] kn, output int at);
        at = -1;
        for (int n = 0; n < 60; n++) begin
            step(1'b0, kn);
            if (reset_req == 3'b111) begin at = ecount; break; end
        end
        if (at < 0) chk("wait_reset_req_timeout", 0, 1);
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] kn;
        logic [2:0] kp;
        logic [2:0] ke;
        logic       hold;
        logic [2:0] req;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int x, f, e0, cnt;

        // Clean press of key 0 then release; index 1 is E0 of the press, 8 of the release.
        tbl[0] = '{1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 3'b000};
        for (int i = 1; i < 14; i++) begin
            tbl[i].rst  = 1'b0;
            tbl[i].kn   = (i < 8) ? 3'b110 : 3'b111;
            tbl[i].kp   = (i >= 6 && i < 13) ? 3'b001 : 3'b000;
            tbl[i].ke   = (i == 6) ? 3'b001 : 3'b000;
            tbl[i].hold = 1'b0;
            tbl[i].req  = 3'b000;
        end
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].kn);
            checks++;
            if ({key_pressed, key_edge, hold_active, reset_req} !== {tbl[i].kp, tbl[i].ke, tbl[i].hold, tbl[i].req}) begin
                errors++;
                $display("FAIL table[%0d] got kp=%b ke=%b hold=%b req=%b expected kp=%b ke=%b hold=%b req=%b",
                         i, key_pressed, key_edge, hold_active, reset_req,
                         tbl[i].kp, tbl[i].ke, tbl[i].hold, tbl[i].req);
            end
        end

        // Bounce on key 1: toggling every 2 cycles never settles, then one clean press.
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, (((i / 2) % 2) != 0) ? 3'b111 : 3'b101);
            if (key_pressed[1]) cnt++;
        end
        chk("bounce_no_level", cnt, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 3'b101);
            if (key_edge[1]) cnt++;
        end
        chk("bounce_single_edge", cnt, 1);
        run_until_kp(3'b111, 3'b000, x);

        // Gesture fire, no repeat while held, re-fire after release.
        run_until_kp(3'b000, 3'b111, x);
        run_until_req(3'b000, f);
        chk("fire_latency", f - x, H);
        cnt = 1;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 3'b000);
            if (reset_req == 3'b111) cnt++;
        end
        chk("single_pulse_len", cnt, P);
        run_until_kp(3'b111, 3'b000, x);
        run_until_kp(3'b000, 3'b111, x);
        run_until_req(3'b000, f);
        chk("refire_latency", f - x, H);

        // Reset during the second FIRE cycle, then re-detection and a full new hold.
        step(1'b0, 3'b000);
        chk("fire_second_cycle", int'(reset_req), 7);
        step(1'b1, 3'b000);
        chk("reset_mid_fire_outputs", int'({key_pressed, key_edge, hold_active, reset_req}), 0);
        step(1'b0, 3'b000);
        e0 = ecount;
        if (key_pressed != 3'b111) run_until_kp(3'b000, 3'b111, x);
        else x = ecount;
        chk("redetect_latency", x - e0, D + 1);
        run_until_req(3'b000, f);
        chk("post_reset_fire_latency", f - x, H);

        // Aborted hold: key 2 released mid-hold, then a full re-hold is needed.
        run_until_kp(3'b111, 3'b000, x);
        for (int i = 0; i < 3; i++) step(1'b0, 3'b111);
        run_until_kp(3'b000, 3'b111, x);
        step(1'b0, 3'b000);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 3'b100);
            if (reset_req != 3'b000) cnt++;
        end
        chk("abort_no_fire", cnt, 0);
        run_until_kp(3'b000, 3'b111, x);
        run_until_req(3'b000, f);
        chk("abort_refire_latency", f - x, H);

        // Random key activity, biased toward long all-held stretches, with occasional reset.
        for (int s = 0; s < 40; s++) begin
            logic [2:0] kn;
            int len;
            logic rst;
            if ($urandom_range(0, 2) == 0) begin
                kn = 3'b000; len = $urandom_range(10, 40);
            end else begin
                kn = 3'($urandom); len = $urandom_range(1, 12);
            end
            for (int i = 0; i < len; i++) begin
                rst = ($urandom_range(0, 199) == 0);
                step(rst, kn);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
